// File: rtl/traffic_phase_scheduler_if.sv
// Bus between the junction controller and its environment: queue counts in,
// lamp buses plus phase status out.
interface traffic_phase_scheduler_if;
  logic [4:0] cnt_main;
  logic [4:0] cnt_mt;
  logic [4:0] cnt_s;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic [2:0] phase;
  logic       phase_start;

  modport master (
    output cnt_main, cnt_mt, cnt_s,
    input  light_M1, light_M2, light_MT, light_S, phase, phase_start
  );

  modport slave (
    input  cnt_main, cnt_mt, cnt_s,
    output light_M1, light_M2, light_MT, light_S, phase, phase_start
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Timed phase sequencer for a four-approach junction; green dwell scales with the
// queue count seen on phase entry, and the side-road phase is skipped without demand.
module traffic_phase_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int GREEN_MIN   = 5,
  parameter int GREEN_MAX   = 20,
  parameter int EXT_PER_VEH = 1,
  parameter int AMBER_T     = 3,
  parameter int ALLRED_T    = 2
) (
  input logic                   clk,
  input logic                   rst,
  traffic_phase_scheduler_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LA = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  typedef enum logic [2:0] {
    P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4, P5 = 3'd5, P6 = 3'd6
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [7:0]      dwell_q, dwell_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pstart_q, pstart_d;
  logic [11:0]     lamps_q, lamps_d;
  logic            tick_s;
  logic            illegal_s;

  function automatic logic [7:0] green_ticks(input logic [4:0] n);
    logic [15:0] t;
    t = 16'(GREEN_MIN) + 16'(n) * 16'(EXT_PER_VEH);
    if (t > 16'(GREEN_MAX)) begin
      t = 16'(GREEN_MAX);
    end else begin
      t = t;
    end
    return t[7:0];
  endfunction

  // Lamp word is {M1, M2, MT, S}; anything outside P0..P5 shows all red.
  function automatic logic [11:0] lamp_decode(input phase_e p);
    logic [11:0] l;
    case (p)
      P0:      l = {LG, LG, LR, LR};
      P1:      l = {LG, LA, LR, LR};
      P2:      l = {LG, LR, LG, LR};
      P3:      l = {LA, LR, LA, LR};
      P4:      l = {LR, LR, LR, LG};
      P5:      l = {LR, LR, LR, LA};
      default: l = {LR, LR, LR, LR};
    endcase
    return l;
  endfunction

  assign tick_s    = (presc_q == PW'(TICK_DIV - 1));
  assign illegal_s = (phase_q > P6);

  // Next-state: prescaler, dwell countdown and phase sequencing.
  always_comb begin
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    presc_d  = presc_q + PW'(1);
    pstart_d = 1'b0;
    if (illegal_s) begin
      phase_d = P6;
      dwell_d = 8'(ALLRED_T);
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
      if (dwell_q <= 8'd1) begin
        pstart_d = 1'b1;
        case (phase_q)
          P0: begin phase_d = P1; dwell_d = 8'(AMBER_T); end
          P1: begin phase_d = P2; dwell_d = green_ticks(bus.cnt_mt); end
          P2: begin phase_d = P3; dwell_d = 8'(AMBER_T); end
          P3: begin
            if (bus.cnt_s != 5'd0) begin
              phase_d = P4;
              dwell_d = green_ticks(bus.cnt_s);
            end else begin
              phase_d = P6;
              dwell_d = 8'(ALLRED_T);
            end
          end
          P4: begin phase_d = P5; dwell_d = 8'(AMBER_T); end
          P5: begin phase_d = P6; dwell_d = 8'(ALLRED_T); end
          P6: begin phase_d = P0; dwell_d = green_ticks(bus.cnt_main); end
          default: begin
            phase_d  = P6;
            dwell_d  = 8'(ALLRED_T);
            pstart_d = 1'b0;
          end
        endcase
      end else begin
        dwell_d = dwell_q - 8'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
    lamps_d = lamp_decode(phase_d);
  end

  // State register; lamps are decoded from the next phase so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= P6;
      dwell_q  <= 8'(ALLRED_T);
      presc_q  <= '0;
      pstart_q <= 1'b0;
      lamps_q  <= {LR, LR, LR, LR};
    end else begin
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      presc_q  <= presc_d;
      pstart_q <= pstart_d;
      lamps_q  <= lamps_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_start = pstart_q;
  assign bus.light_M1    = lamps_q[11:9];
  assign bus.light_M2    = lamps_q[8:6];
  assign bus.light_MT    = lamps_q[5:3];
  assign bus.light_S     = lamps_q[2:0];

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler at TICK_DIV=2: table of full-cycle
// phase timings plus hand-written reset, mid-phase sampling and skip sequences.
module tb_traffic_phase_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_scheduler_if bus_if ();

  traffic_phase_scheduler #(
    .TICK_DIV(2), .GREEN_MIN(5), .GREEN_MAX(20), .EXT_PER_VEH(1),
    .AMBER_T(3), .ALLRED_T(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      m;
    logic [4:0]      mt;
    logic [4:0]      s;
    logic [6:0][7:0] len;   // expected cycles per phase; 0 means phase skipped
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_lamps(input int ph);
    case (ph)
      0:       return {3'b001, 3'b001, 3'b100, 3'b100};
      1:       return {3'b001, 3'b010, 3'b100, 3'b100};
      2:       return {3'b001, 3'b100, 3'b001, 3'b100};
      3:       return {3'b010, 3'b100, 3'b010, 3'b100};
      4:       return {3'b100, 3'b100, 3'b100, 3'b001};
      5:       return {3'b100, 3'b100, 3'b100, 3'b010};
      default: return {3'b100, 3'b100, 3'b100, 3'b100};
    endcase
  endfunction

  // Every cycle: lamps agree with phase, and S never shows go while a main approach does.
  always @(negedge clk) begin
    if (!$isunknown(bus_if.phase)) begin
      chk("lamp_decode",
          int'({bus_if.light_M1, bus_if.light_M2, bus_if.light_MT, bus_if.light_S}),
          int'(exp_lamps(int'(bus_if.phase))));
      chk("safety",
          int'((bus_if.light_S != 3'b100) &&
               ((bus_if.light_M1 != 3'b100) || (bus_if.light_M2 != 3'b100) ||
                (bus_if.light_MT != 3'b100))), 0);
    end
  end

  task automatic wait_start(input int ph);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (bus_if.phase_start && int'(bus_if.phase) == ph) found = 1'b1;
    end
    if (!found) chk("wait_start_timeout", ph, -1);
  endtask

  // Call in a phase_start cycle; returns that phase and its length, ends at the next start.
  task automatic measure(output int ph, output int len);
    bit done;
    ph   = int'(bus_if.phase);
    len  = 1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus_if.phase_start) done = 1'b1;
      else len++;
    end
    if (!done) chk("measure_timeout", len, -1);
  endtask

  task automatic check_restart(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk({tag, "_hold_phase"}, int'(bus_if.phase), 6);
        chk({tag, "_hold_pstart"}, int'(bus_if.phase_start), 0);
      end else begin
        chk({tag, "_p0_phase"}, int'(bus_if.phase), 0);
        chk({tag, "_p0_pstart"}, int'(bus_if.phase_start), 1);
        chk({tag, "_p0_m1"}, int'(bus_if.light_M1), 1);
        chk({tag, "_p0_m2"}, int'(bus_if.light_M2), 1);
        chk({tag, "_p0_mt"}, int'(bus_if.light_MT), 4);
        chk({tag, "_p0_s"}, int'(bus_if.light_S), 4);
      end
    end
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, int'(bus_if.phase_start), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_phase"}, int'(bus_if.phase), 6);
    chk({tag, "_pstart"}, int'(bus_if.phase_start), 0);
    chk({tag, "_lamps"},
        int'({bus_if.light_M1, bus_if.light_M2, bus_if.light_MT, bus_if.light_S}), 12'h924);
  endtask

  initial begin
    int ph;
    int len;
    bus_if.cnt_main = 5'd0;
    bus_if.cnt_mt   = 5'd0;
    bus_if.cnt_s    = 5'd0;

    // green(n) = min(5+n,20) ticks, 2 cycles/tick; amber 6 cycles, all-red 4 cycles
    vecs[0] = '{m: 5'd3,  mt: 5'd31, s: 5'd2, len: {8'd4, 8'd6, 8'd14, 8'd6, 8'd40, 8'd6, 8'd16}};
    vecs[1] = '{m: 5'd0,  mt: 5'd0,  s: 5'd0, len: {8'd4, 8'd0, 8'd0,  8'd6, 8'd10, 8'd6, 8'd10}};
    vecs[2] = '{m: 5'd15, mt: 5'd16, s: 5'd1, len: {8'd4, 8'd6, 8'd12, 8'd6, 8'd40, 8'd6, 8'd40}};
    vecs[3] = '{m: 5'd7,  mt: 5'd1,  s: 5'd0, len: {8'd4, 8'd0, 8'd0,  8'd6, 8'd12, 8'd6, 8'd24}};

    // Reset held three cycles, then first P0 entry four cycles after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    check_restart("reset");

    for (int v = 0; v < 4; v++) begin
      wait_start(6);
      bus_if.cnt_main = vecs[v].m;
      bus_if.cnt_mt   = vecs[v].mt;
      bus_if.cnt_s    = vecs[v].s;
      wait_start(0);
      for (int p = 0; p < 7; p++) begin
        if (vecs[v].len[p] != 8'd0) begin
          measure(ph, len);
          chk($sformatf("vec%0d_seq_p%0d", v, p), ph, p);
          chk($sformatf("vec%0d_len_p%0d", v, p), len, int'(vecs[v].len[p]));
        end
      end
    end

    // cnt_s sampled at P4 entry; a mid-phase change must not stretch the green.
    bus_if.cnt_s = 5'd2;
    wait_start(4);
    bus_if.cnt_s = 5'd31;
    measure(ph, len);
    chk("s_midphase_phase", ph, 4);
    chk("s_midphase_len", len, 14);
    chk("s_midphase_next", int'(bus_if.phase), 5);
    chk("s_midphase_amber", int'(bus_if.light_S), 2);

    // Demand present on P3 entry but gone in the exit cycle: S is skipped.
    bus_if.cnt_s = 5'd3;
    wait_start(3);
    repeat (5) @(negedge clk);
    chk("skip_late_still_p3", int'(bus_if.phase), 3);
    bus_if.cnt_s = 5'd0;
    @(negedge clk);
    chk("skip_late_phase", int'(bus_if.phase), 6);
    chk("skip_late_pstart", int'(bus_if.phase_start), 1);

    // One-cycle reset in the middle of P2.
    wait_start(2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    check_restart("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
